// File: rtl/file2bus_pkg.sv
// rtl/file2bus_pkg.sv - shared File2Bus datapath constants
package file2bus_pkg;

   // default buffer geometry between the file reader and the bus master
   localparam int F2B_DATA_WIDTH = 22;
   localparam int F2B_DEPTH      = 16;

   // read-side presentation modes of sync_fifo_pro
   localparam int FIFO_STD  = 0;
   localparam int FIFO_FWFT = 1;

   // next pointer value with an explicit wrap at depth-1, so any depth is fully usable
   function automatic int wrap_inc(input int ptr, input int depth);
      return (ptr == depth - 1) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - DEPTH x DATA_WIDTH register array, sync write, async read
module fifo_mem #(
   parameter int DATA_WIDTH = 22,
   parameter int DEPTH      = 16,
   localparam int AW        = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [AW-1:0]         waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [AW-1:0]         raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // storage is deliberately not reset; only occupancy state is cleared
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_pro.sv
// rtl/sync_fifo_pro.sv - single-clock FIFO with count, thresholds, sticky errors and FWFT option
module sync_fifo_pro
   import file2bus_pkg::*;
#(
   parameter int DATA_WIDTH = F2B_DATA_WIDTH,
   parameter int DEPTH      = F2B_DEPTH,
   parameter int FWFT       = FIFO_STD,
   parameter int AF_LEVEL   = DEPTH - 2,
   parameter int AE_LEVEL   = 2,
   localparam int AW        = $clog2(DEPTH),
   localparam int CW        = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  rd_valid,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [CW-1:0]         count,
   output logic                  overflow,
   output logic                  underflow,
   input  logic                  err_clr
);

   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [CW-1:0]         count_q;
   logic                  wr_acc;
   logic                  rd_acc;
   logic [DATA_WIDTH-1:0] head;

   // status is decoded from the registered count only; pointers never decide full/empty
   assign full         = (count_q == CW'(DEPTH));
   assign empty        = (count_q == '0);
   assign almost_full  = (count_q >= CW'(AF_LEVEL));
   assign almost_empty = (count_q <= CW'(AE_LEVEL));
   assign count        = count_q;

   // a full FIFO still drains and an empty FIFO still fills when both are requested
   assign wr_acc = wr_en & ~full;
   assign rd_acc = rd_en & ~empty;

   // pointers advance on accepted transfers and wrap by compare to support non-power-of-two depth
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_acc) begin
            wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
         end
         if (rd_acc) begin
            rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
         end
      end
   end

   // occupancy: simultaneous accepted write and read cancel out
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_q + CW'(wr_acc) - CW'(rd_acc);
      end
   end

   // sticky error flags; a fresh error in the same cycle as err_clr keeps the flag set
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_en & full) begin
            overflow <= 1'b1;
         end else if (err_clr) begin
            overflow <= 1'b0;
         end
         if (rd_en & empty) begin
            underflow <= 1'b1;
         end else if (err_clr) begin
            underflow <= 1'b0;
         end
      end
   end

   fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_mem (
      .clk   (clk),
      .we    (wr_acc),
      .waddr (wr_ptr),
      .wdata (data_in),
      .raddr (rd_ptr),
      .rdata (head)
   );

   if (FWFT == FIFO_FWFT) begin : g_fwft
      // head word is presented directly; forced to zero while empty so reset reads back 0
      always_comb begin
         data_out = '0;
         rd_valid = ~empty;
         if (!empty) begin
            data_out = head;
         end
      end
   end else begin : g_std
      logic [DATA_WIDTH-1:0] data_q;
      logic                  valid_q;

      // registered read: capture head on an accepted pop, otherwise hold the last word
      always_ff @(posedge clk) begin
         if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
         end else begin
            valid_q <= rd_acc;
            if (rd_acc) begin
               data_q <= head;
            end
         end
      end

      assign data_out = data_q;
      assign rd_valid = valid_q;
   end

endmodule

// File: tb/tb_sync_fifo_pro.sv
// tb/tb_sync_fifo_pro.sv - self-checking bench for sync_fifo_pro (DEPTH 16 std, DEPTH 15 std, DEPTH 16 FWFT)
module tb_sync_fifo_pro;

   localparam int DW = 22;
   localparam int NI = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          wr_en = 1'b0;
   logic          rd_en = 1'b0;
   logic          err_clr = 1'b0;
   logic [DW-1:0] data_in = '0;

   logic [DW-1:0] dout [NI];
   logic          rv   [NI];
   logic          full [NI];
   logic          empty[NI];
   logic          af   [NI];
   logic          ae   [NI];
   logic          ovf  [NI];
   logic          unf  [NI];
   logic [4:0]    cnt16a;
   logic [3:0]    cnt15;
   logic [4:0]    cnt16f;

   always #5 clk = ~clk;

   sync_fifo_pro #(.DATA_WIDTH(DW), .DEPTH(16), .FWFT(0)) u16 (
      .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
      .data_out(dout[0]), .rd_valid(rv[0]), .full(full[0]), .empty(empty[0]),
      .almost_full(af[0]), .almost_empty(ae[0]), .count(cnt16a),
      .overflow(ovf[0]), .underflow(unf[0]), .err_clr(err_clr));

   sync_fifo_pro #(.DATA_WIDTH(DW), .DEPTH(15), .FWFT(0)) u15 (
      .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
      .data_out(dout[1]), .rd_valid(rv[1]), .full(full[1]), .empty(empty[1]),
      .almost_full(af[1]), .almost_empty(ae[1]), .count(cnt15),
      .overflow(ovf[1]), .underflow(unf[1]), .err_clr(err_clr));

   sync_fifo_pro #(.DATA_WIDTH(DW), .DEPTH(16), .FWFT(1)) uf (
      .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
      .data_out(dout[2]), .rd_valid(rv[2]), .full(full[2]), .empty(empty[2]),
      .almost_full(af[2]), .almost_empty(ae[2]), .count(cnt16f),
      .overflow(ovf[2]), .underflow(unf[2]), .err_clr(err_clr));

   // reference model: a queue of words per instance plus the architectural flags
   int            depth[NI] = '{16, 15, 16};
   int            afl  [NI] = '{14, 13, 14};
   int            ael  [NI] = '{2, 2, 2};
   bit            fw   [NI] = '{1'b0, 1'b0, 1'b1};
   logic [DW-1:0] mq   [NI][$];
   logic [DW-1:0] m_dout[NI];
   bit            m_rv [NI];
   bit            m_ovf[NI];
   bit            m_unf[NI];

   int    n_assert = 0;
   int    n_fail   = 0;
   string phase    = "init";

   function automatic logic [31:0] cnt_of(input int i);
      case (i)
         0:       return 32'(cnt16a);
         1:       return 32'(cnt15);
         default: return 32'(cnt16f);
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s/%s: observed %0h expected %0h", phase, tag, obs, exp);
      end
   endtask

   // advance the model by one clock using the inputs currently applied
   task automatic model_step();
      for (int i = 0; i < NI; i++) begin
         if (rst) begin
            mq[i].delete();
            m_dout[i] = '0;
            m_rv[i]   = 1'b0;
            m_ovf[i]  = 1'b0;
            m_unf[i]  = 1'b0;
         end else begin
            bit is_full;
            bit is_empty;
            bit wa;
            bit ra;
            is_full  = (mq[i].size() == depth[i]);
            is_empty = (mq[i].size() == 0);
            wa = wr_en && !is_full;
            ra = rd_en && !is_empty;
            if (wr_en && is_full) m_ovf[i] = 1'b1;
            else if (err_clr)     m_ovf[i] = 1'b0;
            if (rd_en && is_empty) m_unf[i] = 1'b1;
            else if (err_clr)      m_unf[i] = 1'b0;
            m_rv[i] = ra;
            if (ra) m_dout[i] = mq[i].pop_front();
            if (wa) mq[i].push_back(data_in);
         end
      end
   endtask

   task automatic check_all();
      for (int i = 0; i < NI; i++) begin
         int n;
         n = mq[i].size();
         chk($sformatf("u%0d/count", i), cnt_of(i), 32'(n));
         chk($sformatf("u%0d/full", i), 32'(full[i]), 32'(n == depth[i]));
         chk($sformatf("u%0d/empty", i), 32'(empty[i]), 32'(n == 0));
         chk($sformatf("u%0d/almost_full", i), 32'(af[i]), 32'(n >= afl[i]));
         chk($sformatf("u%0d/almost_empty", i), 32'(ae[i]), 32'(n <= ael[i]));
         chk($sformatf("u%0d/overflow", i), 32'(ovf[i]), 32'(m_ovf[i]));
         chk($sformatf("u%0d/underflow", i), 32'(unf[i]), 32'(m_unf[i]));
         if (fw[i]) begin
            chk($sformatf("u%0d/rd_valid", i), 32'(rv[i]), 32'(n != 0));
            if (n != 0) chk($sformatf("u%0d/data_out", i), 32'(dout[i]), 32'(mq[i][0]));
         end else begin
            chk($sformatf("u%0d/rd_valid", i), 32'(rv[i]), 32'(m_rv[i]));
            chk($sformatf("u%0d/data_out", i), 32'(dout[i]), 32'(m_dout[i]));
         end
      end
   endtask

   task automatic cycle(input bit w, input bit r, input logic [DW-1:0] d,
                        input bit c = 1'b0, input bit rs = 1'b0);
      wr_en   = w;
      rd_en   = r;
      data_in = d;
      err_clr = c;
      rst     = rs;
      model_step();
      @(posedge clk);
      #1;
      check_all();
   endtask

   initial begin
      // reset
      phase = "reset";
      cycle(0, 0, '0, 0, 1);
      cycle(0, 0, '0, 0, 1);
      chk("cnt", cnt_of(0), 0);
      chk("empty", 32'(empty[0]), 1);
      chk("full", 32'(full[0]), 0);
      chk("dout", 32'(dout[0]), 0);
      chk("ae", 32'(ae[0]), 1);
      chk("af", 32'(af[0]), 0);

      // fill 0x1..0x10 then one extra write
      phase = "fill";
      for (int k = 1; k <= 17; k++) begin
         cycle(1, 0, DW'(k));
         if (k <= 16) begin
            chk("cnt", cnt_of(0), 32'(k));
            chk("af", 32'(af[0]), 32'(k >= 14));
         end
      end
      chk("full16", 32'(full[0]), 1);
      chk("cnt16", cnt_of(0), 16);
      chk("ovf17", 32'(ovf[0]), 1);
      chk("full15", 32'(full[1]), 1);
      chk("cnt15", cnt_of(1), 15);

      phase = "clr";
      cycle(0, 0, '0, 1);
      chk("ovf", 32'(ovf[0]), 0);

      // write+read while full: read wins, write raises overflow
      phase = "simul_full";
      cycle(1, 1, 'h11);
      chk("cnt16", cnt_of(0), 15);
      chk("ovf", 32'(ovf[0]), 1);
      chk("rv", 32'(rv[0]), 1);
      chk("dout", 32'(dout[0]), 1);
      chk("cnt15", cnt_of(1), 14);

      phase = "drain";
      for (int k = 2; k <= 16; k++) begin
         cycle(0, 1, '0);
         chk("dout", 32'(dout[0]), 32'(k));
         chk("rv", 32'(rv[0]), 1);
         chk("ae", 32'(ae[0]), 32'((16 - k) <= 2));
      end
      chk("empty", 32'(empty[0]), 1);
      cycle(0, 0, '0);
      chk("rv_idle", 32'(rv[0]), 0);
      chk("dout_hold", 32'(dout[0]), 'h10);

      phase = "underflow";
      cycle(0, 1, '0);
      chk("unf_set", 32'(unf[0]), 1);
      cycle(0, 1, '0, 1);
      chk("unf_set_wins", 32'(unf[0]), 1);
      cycle(0, 0, '0, 1);
      chk("unf_clr", 32'(unf[0]), 0);

      // write+read while empty: write wins, read raises underflow
      phase = "simul_empty";
      cycle(1, 1, 'h21);
      chk("cnt", cnt_of(0), 1);
      chk("unf", 32'(unf[0]), 1);
      for (int k = 0; k < 4; k++) cycle(1, 0, DW'('h22 + k));
      chk("cnt5", cnt_of(0), 5);
      cycle(1, 1, 'h26);
      chk("cnt5_hold", cnt_of(0), 5);
      chk("dout", 32'(dout[0]), 'h21);

      // reset with 7 words stored
      phase = "mid_reset";
      cycle(1, 0, 'h27);
      cycle(1, 0, 'h28);
      chk("cnt7", cnt_of(0), 7);
      cycle(0, 0, '0, 0, 1);
      chk("cnt", cnt_of(0), 0);
      chk("empty", 32'(empty[0]), 1);
      chk("dout", 32'(dout[0]), 0);
      chk("unf", 32'(unf[0]), 0);
      chk("ovf", 32'(ovf[0]), 0);
      cycle(1, 0, 'h55);
      chk("fwft_new", 32'(dout[2]), 'h55);
      cycle(0, 1, '0);
      chk("std_new", 32'(dout[0]), 'h55);

      phase = "fwft";
      cycle(1, 0, 'hABC);
      chk("empty", 32'(empty[2]), 0);
      chk("dout", 32'(dout[2]), 'hABC);
      chk("rv", 32'(rv[2]), 1);
      cycle(0, 1, '0);
      chk("empty_pop", 32'(empty[2]), 1);
      chk("rv_pop", 32'(rv[2]), 0);

      // continuous push/pop with stalls, walking the pointers across the wrap several times
      phase = "wrap";
      for (int k = 0; k < 60; k++) begin
         cycle((k % 7) != 3, (k >= 3) && ((k % 5) != 4), DW'('h100 + k));
      end
      for (int k = 0; k < 20; k++) cycle(0, 1, '0);

      // random traffic with phases biased towards full and towards empty
      phase = "random";
      for (int k = 0; k < 1500; k++) begin
         int wp;
         int rp;
         case ((k / 100) % 3)
            0:       begin wp = 80; rp = 25; end
            1:       begin wp = 50; rp = 50; end
            default: begin wp = 20; rp = 80; end
         endcase
         cycle($urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp,
               DW'($urandom), $urandom_range(0, 39) == 0, $urandom_range(0, 399) == 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
